// File: rtl/microm_decoder.sv
// Reassembles the microm bytecode stream (one byte per handshake) into opcode, imm32 and register operands.
// An instruction is presented one cycle after its last byte is accepted; in_ready drops only while a result waits for out_ready.
module microm_decoder #(
  parameter int NUM_REGS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_op,
  output logic [31:0] out_imm,
  output logic [7:0]  out_reg_a,
  output logic [7:0]  out_reg_b,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {OPC, IMM, REGA, REGB} state_t;

  localparam logic [7:0] NREGS = 8'(NUM_REGS);

  state_t      state;
  logic [1:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] imm_q;
  logic [7:0]  rega_q;

  logic acc;
  logic opc_ok;
  logic reg_bad;
  logic two_reg;

  assign in_ready = !rst && !(out_valid && !out_ready);
  assign acc      = in_valid && in_ready;
  assign opc_ok   = (in_data >= 8'h01) && (in_data <= 8'h0C);
  assign reg_bad  = (in_data >= NREGS);
  assign two_reg  = (op_q >= 4'h9);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= OPC;
      cnt       <= 2'd0;
      op_q      <= 4'd0;
      imm_q     <= 32'd0;
      rega_q    <= 8'd0;
      out_valid <= 1'b0;
      out_op    <= 4'd0;
      out_imm   <= 32'd0;
      out_reg_a <= 8'd0;
      out_reg_b <= 8'd0;
      err       <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      err <= 1'b0;
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      // Emits below only happen on an accepted byte, so a held result is never overwritten.
      if (acc) begin
        case (state)
          OPC: begin
            if (opc_ok) begin
              op_q   <= in_data[3:0];
              imm_q  <= 32'd0;
              rega_q <= 8'd0;
              cnt    <= 2'd0;
              if (in_data[3:0] <= 4'h2) begin
                state <= IMM;
              end else if (in_data[3:0] == 4'h7 || in_data[3:0] == 4'h8) begin
                out_valid <= 1'b1;
                out_op    <= in_data[3:0];
                out_imm   <= 32'd0;
                out_reg_a <= 8'd0;
                out_reg_b <= 8'd0;
              end else begin
                state <= REGA;
              end
            end else begin
              err      <= 1'b1;
              err_code <= 2'd1;
            end
          end

          IMM: begin
            case (cnt)
              2'd0:    imm_q[7:0]   <= in_data;
              2'd1:    imm_q[15:8]  <= in_data;
              2'd2:    imm_q[23:16] <= in_data;
              default: imm_q[31:24] <= in_data;
            endcase
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3)
              state <= REGA;
          end

          REGA: begin
            if (reg_bad) begin
              err      <= 1'b1;
              err_code <= 2'd2;
              state    <= OPC;
            end else if (two_reg) begin
              rega_q <= in_data;
              state  <= REGB;
            end else begin
              out_valid <= 1'b1;
              out_op    <= op_q;
              out_imm   <= imm_q;
              out_reg_a <= in_data;
              out_reg_b <= 8'd0;
              state     <= OPC;
            end
          end

          REGB: begin
            if (reg_bad) begin
              err      <= 1'b1;
              err_code <= 2'd2;
            end else begin
              out_valid <= 1'b1;
              out_op    <= op_q;
              out_imm   <= 32'd0;
              out_reg_a <= rega_q;
              out_reg_b <= in_data;
            end
            state <= OPC;
          end

          default: state <= OPC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_microm_decoder.sv
// Directed bench for microm_decoder: a byte-buffer model of the instruction format is compared every cycle.
module tb_microm_decoder;

  localparam int NUM_REGS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_op;
  logic [31:0] out_imm;
  logic [7:0]  out_reg_a;
  logic [7:0]  out_reg_b;
  logic        err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;
  logic started = 1'b0;

  microm_decoder #(.NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_imm(out_imm),
    .out_reg_a(out_reg_a), .out_reg_b(out_reg_b), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: collect accepted bytes of the current instruction and decide once enough have arrived.
  logic        mv, me;
  logic [1:0]  mec;
  logic [3:0]  mop;
  logic [31:0] mimm;
  logic [7:0]  ma, mb;
  logic [7:0]  mbuf [0:5];
  int          mlen;

  always @(posedge clk) begin
    automatic logic [7:0] b [0:5];
    automatic int n, need;
    automatic logic v, e, acc, isreg;
    automatic logic [1:0] ec;
    automatic logic [3:0] fo;
    automatic logic [31:0] fi;
    automatic logic [7:0] fa, fb;
    b = mbuf; n = mlen; v = mv; e = 1'b0; ec = mec;
    fo = mop; fi = mimm; fa = ma; fb = mb;
    if (rst) begin
      n = 0; v = 1'b0; ec = 2'd0; fo = 4'd0; fi = 32'd0; fa = 8'd0; fb = 8'd0;
    end else begin
      acc = in_valid && !(mv && !out_ready);
      if (mv && out_ready) v = 1'b0;
      if (acc) begin
        b[n] = in_data;
        n++;
        if (n == 1 && (b[0] == 8'd0 || b[0] > 8'h0C)) begin
          e = 1'b1; ec = 2'd1; n = 0;
        end else begin
          need  = (b[0] <= 8'd2) ? 6 : (b[0] <= 8'd6) ? 2 : (b[0] <= 8'd8) ? 1 : 3;
          isreg = (b[0] <= 8'd2) ? (n == 6) : (b[0] <= 8'd6) ? (n == 2) :
                  (b[0] >= 8'd9) ? (n >= 2) : 1'b0;
          if (isreg && int'(in_data) >= NUM_REGS) begin
            e = 1'b1; ec = 2'd2; n = 0;
          end else if (n == need) begin
            v  = 1'b1;
            fo = b[0][3:0];
            fi = (b[0] <= 8'd2) ? {b[4], b[3], b[2], b[1]} : 32'd0;
            fa = (b[0] <= 8'd2) ? b[5] : (b[0] <= 8'd8 && b[0] >= 8'd7) ? 8'd0 : b[1];
            fb = (b[0] >= 8'd9) ? b[2] : 8'd0;
            n  = 0;
          end
        end
      end
    end
    mbuf <= b; mlen <= n; mv <= v; me <= e; mec <= ec;
    mop <= fo; mimm <= fi; ma <= fa; mb <= fb;
  end

  logic [51:0] got_q [$];
  logic [1:0]  err_q [$];

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'(!rst && !(mv && !out_ready)));
      chk("out_valid", 32'(out_valid), 32'(mv));
      chk("out_op", 32'(out_op), 32'(mop));
      chk("out_imm", out_imm, mimm);
      chk("out_reg_a", 32'(out_reg_a), 32'(ma));
      chk("out_reg_b", 32'(out_reg_b), 32'(mb));
      chk("err", 32'(err), 32'(me));
      chk("err_code", 32'(err_code), 32'(mec));
      if (out_valid === 1'b1 && out_ready && !rst)
        got_q.push_back({out_op, out_imm, out_reg_a, out_reg_b});
      if (err === 1'b1)
        err_q.push_back(err_code);
    end
  end

  task automatic send(input logic [7:0] b);
    automatic int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=%b exp 1 byte %h", in_ready, b);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s [], input int len);
    for (int i = 0; i < len; i++) send(s[i]);
  endtask

  function automatic logic [51:0] mk(input logic [3:0] op, input logic [31:0] imm,
                                     input logic [7:0] a, input logic [7:0] b);
    return {op, imm, a, b};
  endfunction

  initial begin
    automatic logic [7:0] s [];
    automatic logic [51:0] exp_q [$];
    automatic logic [1:0]  exp_e [$];
    automatic int nmin;

    fork
      begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
      end
    join_none

    @(posedge clk);
    #1 started = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2;

    s = '{8'h01, 8'h2A, 8'h00, 8'h00, 8'h00, 8'h03};
    send_seq(s, 6);
    @(negedge clk);
    chk("movi_valid", 32'(out_valid), 32'd1);
    chk("movi_op", 32'(out_op), 32'h1);
    chk("movi_imm", out_imm, 32'h0000002A);
    chk("movi_ra", 32'(out_reg_a), 32'd3);
    @(posedge clk);
    #2;

    s = '{8'h02, 8'h00, 8'h00, 8'h80, 8'h3F, 8'h05, 8'h0C, 8'h02, 8'h07};
    send_seq(s, 9);
    @(negedge clk);
    chk("rmovf_op", 32'(out_op), 32'hC);
    chk("rmovf_rb", 32'(out_reg_b), 32'd7);
    @(posedge clk);
    #2;

    out_ready = 1'b0;
    send(8'h07);
    in_valid = 1'b1;
    in_data  = 8'h08;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_op", 32'(out_op), 32'h7);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    @(posedge clk);
    #2 out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_op", 32'(out_op), 32'h8);
    @(posedge clk);
    #2 out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    s = '{8'hFF, 8'h07};
    send_seq(s, 2);
    s = '{8'h03, 8'h10, 8'h09, 8'h10, 8'h04};
    send_seq(s, 5);
    @(negedge clk);
    chk("bad_reg_no_emit", 32'(out_valid), 32'd0);
    @(posedge clk);
    #2;
    send(8'h01);

    s = '{8'h01, 8'hAA, 8'hBB};
    send_seq(s, 3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_imm", out_imm, 32'd0);
    chk("mid_rst_op", 32'(out_op), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    send(8'h07);
    @(negedge clk);
    chk("after_rst_op", 32'(out_op), 32'h7);
    chk("after_rst_imm", out_imm, 32'd0);
    @(posedge clk);
    #2;

    s = '{8'h07, 8'h07, 8'h07};
    send_seq(s, 3);
    repeat (4) @(posedge clk);
    #2;

    exp_q = '{mk(4'h1, 32'h2A, 8'd3, 8'd0), mk(4'h2, 32'h3F800000, 8'd5, 8'd0),
              mk(4'hC, 32'd0, 8'd2, 8'd7), mk(4'h7, 32'd0, 8'd0, 8'd0),
              mk(4'h8, 32'd0, 8'd0, 8'd0), mk(4'h7, 32'd0, 8'd0, 8'd0),
              mk(4'h4, 32'd0, 8'd1, 8'd0), mk(4'h7, 32'd0, 8'd0, 8'd0),
              mk(4'h7, 32'd0, 8'd0, 8'd0), mk(4'h7, 32'd0, 8'd0, 8'd0),
              mk(4'h7, 32'd0, 8'd0, 8'd0)};
    exp_e = '{2'd1, 2'd2, 2'd2};

    chk("emit_count", 32'(got_q.size()), 32'(exp_q.size()));
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      chk($sformatf("emit%0d_op", i), 32'(got_q[i][51:48]), 32'(exp_q[i][51:48]));
      chk($sformatf("emit%0d_imm", i), got_q[i][47:16], exp_q[i][47:16]);
      chk($sformatf("emit%0d_regs", i), 32'(got_q[i][15:0]), 32'(exp_q[i][15:0]));
    end
    chk("err_count", 32'(err_q.size()), 32'(exp_e.size()));
    nmin = (err_q.size() < exp_e.size()) ? err_q.size() : exp_e.size();
    for (int i = 0; i < nmin; i++)
      chk($sformatf("err%0d_code", i), 32'(err_q[i]), 32'(exp_e[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/microm_decoder.md
# microm_decoder

Byte-stream instruction decoder for the microm execution core. It consumes the packed bytecode stream one byte per handshake and reassembles each instruction into opcode, 32-bit immediate and register operands. It presents one decoded instruction at a time to the execute stage over a valid/ready interface. It is the producer side of the instruction set the execute stage implements: movi/movf, popi/popf, stori/storf, copyi/copyf, rcopyi/rcopyf and rmovi/rmovf.

## Interface
- NUM_REGS, 16: register count per file (int and float); legal register index is 0..NUM_REGS-1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a byte is offered on in_data.
- in_data  in  8  bytecode byte.
- in_ready  out  1  decoder accepts in_data this cycle.
- out_valid  out  1  decoded instruction held on out_* fields.
- out_ready  in  1  execute stage takes the instruction.
- out_op  out  4  opcode (0x1..0xC, encoding below).
- out_imm  out  32  immediate: int or f32 bit pattern. Zero for opcodes without an immediate.
- out_reg_a  out  8  first register operand (reg). Zero if unused.
- out_reg_b  out  8  second register operand (reg2). Zero if unused.
- err  out  1  one-cycle pulse on a decode error.
- err_code  out  2  1 = unknown opcode, 2 = register index out of range; holds its last value between pulses.

## Operation
- Encoding: opcode byte first, then operands. The immediate is little-endian, 4 bytes.
  - 0x1 movi: imm32, reg.
  - 0x2 movf: imm32, reg.
  - 0x3 popi, 0x4 popf, 0x5 stori, 0x6 storf: reg.
  - 0x7 copyi, 0x8 copyf: no operands.
  - 0x9 rcopyi, 0xA rcopyf, 0xB rmovi, 0xC rmovf: reg, reg2.
- FSM states:
  - OPC: expect an opcode. Next state is IMM for 0x1/0x2, REGA for 0x3-0x6 and 0x9-0xC. For 0x7/0x8 the decoder emits immediately and stays in OPC.
  - IMM: 2-bit byte counter. Byte k loads imm[8k+7:8k]. After k=3, go to REGA.
  - REGA: latch reg. Go to REGB for 0x9-0xC; otherwise emit and go to OPC.
  - REGB: latch reg2, emit, go to OPC.
- The FSM only advances on an accepted byte (in_valid && in_ready).
- Emit: load the out_* registers and set out_valid. The out_* registers are not modified while out_valid && !out_ready.
- in_ready = !rst && !(out_valid && !out_ready). A byte may therefore complete a new instruction in the same cycle the previous one is consumed; the out_* registers reload and out_valid stays high.
- Unknown opcode (0x0, 0xD-0xFF):
  - err pulses with err_code=1.
  - The byte is dropped; the FSM stays in OPC.
  - The next accepted byte is treated as an opcode.
- Register byte >= NUM_REGS, checked in both REGA and REGB:
  - err pulses with err_code=2.
  - The partial instruction is discarded and nothing is emitted.
  - The FSM returns to OPC.
  - For 0x9-0xC with a bad reg, the reg2 byte is not consumed; it is parsed as an opcode.
- out_imm, out_reg_a and out_reg_b are zero-filled for fields the opcode does not use. There is no stale data from a prior instruction.

## Timing
- Reset values: state=OPC, byte counter=0, out_valid=0, out_op=0, out_imm=0, out_reg_a=0, out_reg_b=0, err=0, err_code=0. in_ready is 0 during rst and 1 in the first cycle after.
- Reset mid-instruction discards all partial fields. The first accepted byte after reset is an opcode.
- Latency: the final byte of an instruction is accepted in cycle N; out_valid=1 with the full fields in cycle N+1. For 0x7/0x8 the final byte is the opcode byte.
- err asserts in cycle N+1 after the offending byte is accepted in cycle N, for exactly one cycle.
- Throughput: one byte per cycle when out_ready is held high. copyi back-to-back yields one instruction per cycle.
- out_valid stays high until the cycle out_ready is sampled high. It then drops unless a new emit happens in the same cycle.

## Test plan
- movi 42 to r3: bytes 01 2A 00 00 00 03 on consecutive cycles with out_ready=1. Expect out_valid one cycle after the 6th byte with op=0x1, imm=0x0000002A, reg_a=3, reg_b=0.
- movf 1.0 to r5, then rmovf r2->r7: bytes 02 00 00 80 3F 05 0C 02 07. Expect first op=0x2, imm=0x3F800000, reg_a=5. Expect second op=0xC, imm=0, reg_a=2, reg_b=7.
- Back-pressure: send 07 08 with out_ready=0.
  - Expect op=0x7 held and in_ready=0, with 08 not accepted.
  - Raise out_ready for 1 cycle: 08 is accepted that cycle, op=0x8 is presented next cycle, and no instruction is lost or duplicated.
- Unknown opcode: FF 07. Expect err pulse with err_code=1, no emit for FF, then op=0x7.
- Bad register (NUM_REGS=16): 03 10 then 09 10 04. Expect an err_code=2 pulse for each bad reg and no emit; 04 is decoded as an opcode and waits for its reg.
- Reset mid-instruction: 01 AA BB, assert rst 1 cycle, then 07. Expect all outputs zero during reset, then op=0x7 with imm=0.
